wavetable_voice_player: RTL
===========================

Name: wavetable_voice_player

Overview:
Next-generation sample player. It plays a clip from an external sample RAM using a fixed-point phase accumulator, so pitch is fractional rather than an integer prescale. Output is linearly interpolated between adjacent samples. Supports loop and one-shot modes, trigger restart and a per-note duration limit. Sits between the clip RAM and the I2S/mixer path; runs on mclk and produces one output per sample_tick.

Parameters:
CLIP_LEN, 1024, clip depth in samples; power of 2, >= 4; AW = $clog2(CLIP_LEN)
DATA_W, 16, signed sample width
FRAC_BITS, 16, fractional bits of phase and phase_inc
INC_W, 24, width of phase_inc (unsigned, FRAC_BITS fractional bits)
DUR_W, 16, width of duration

Ports:
mclk  in  1  master clock (256x sample rate)
rst  in  1  reset; asynchronous, active-high
sample_tick  in  1  one-cycle strobe, one per output sample
trigger  in  1  one-cycle strobe: (re)start note from index 0
mode  in  1  0 = loop, 1 = one-shot; captured at trigger
phase_inc  in  INC_W  index step per sample; captured at each accepted tick
duration  in  DUR_W  samples per note, 0 = unlimited; captured at trigger
rd_addr  out  AW  clip RAM read address
rd_data  in  DATA_W  signed clip RAM data, valid 1 cycle after rd_addr
sample  out  DATA_W  signed interpolated sample, held between valids
valid  out  1  one-cycle pulse when sample updates
playing  out  1  note active
overrun  out  1  one-cycle pulse when a tick arrives while busy (tick dropped)

Behaviour:
- Reset (async): sample=0, valid=0, playing=0, overrun=0, rd_addr=0, phase=0, dur_cnt=0, trig_pend=0, FSM=IDLE.
- Phase register: AW+FRAC_BITS bits. idx = phase[AW+FRAC_BITS-1:FRAC_BITS]; frac = phase[FRAC_BITS-1:0].
- FSM states and transitions:
  - IDLE: on tick, go to FETCH_A.
  - FETCH_A: rd_addr=idx.
  - FETCH_B: rd_addr=nidx; capture a=rd_data.
  - LERP: capture b=rd_data; register the interpolated result.
  - OUT: drive sample and valid, update phase and counters, return to IDLE.
- Latency: valid asserts exactly 4 mclk after the accepted tick.
- nidx: in loop mode, (idx+1) mod CLIP_LEN; in one-shot mode at idx=CLIP_LEN-1, nidx=idx (hold last sample).
- Arithmetic:
  - diff = b - a, computed at DATA_W+1 bits signed.
  - prod = diff * frac, with frac zero-extended.
  - result = a + (prod >>> FRAC_BITS), arithmetic shift, i.e. floor.
  - The result always lies in [min(a,b), max(a,b)]; truncate to DATA_W with no saturation logic.
- Not playing: a tick still runs the FSM (same 4-cycle latency) but sample=0; phase and counters are unchanged.
- OUT update when playing:
  - phase += phase_inc.
  - Loop mode: phase wraps modulo CLIP_LEN<<FRAC_BITS.
  - One-shot mode: if the sum >= CLIP_LEN<<FRAC_BITS, playing<=0 and phase holds.
  - dur_cnt += 1. If duration!=0 and dur_cnt+1 == duration, playing<=0.
- Trigger:
  - In IDLE: applied immediately: phase=0, dur_cnt=0, playing=1, mode and duration captured.
  - In any other state: trig_pend set; applied in OUT instead of the phase/counter update. That sample's value is unaffected.
  - Trigger and tick in the same cycle in IDLE: trigger first, so the tick plays index 0.
- Tick while FSM not in IDLE: ignored; overrun pulses that cycle.
- phase_inc=0: repeats the current sample indefinitely, which is legal.
- phase_inc >= CLIP_LEN<<FRAC_BITS: loop wraps modulo; one-shot ends on the first step.
- Reset mid-operation: all state returns to reset values immediately; no valid for the in-flight tick.

Decomposition:
- Package player_pkg:
  - typedef enum player_state_t {IDLE, FETCH_A, FETCH_B, LERP, OUT}
  - typedef enum play_mode_t {MODE_LOOP, MODE_ONESHOT}
  - typedef sample_t as logic signed [15:0]
  - localparam DEFAULT_FRAC_BITS = 16
- Sub-module player_lerp: takes a, b and frac; produces the registered interpolation result in the LERP cycle; parameters DATA_W and FRAC_BITS. Lets the bench check the math independently.

Test Plan:
Bench configuration for all scenarios: CLIP_LEN=8, FRAC_BITS=4, ROM[i] = 1000*i.
1. Half-step loop: trigger, mode=0, phase_inc=0x08, ticks every 256 clk -> samples 0, 500, 1000, ..., 7000, 3500 (wrap between 7000 and 0), 0. valid is exactly 4 clk after each tick.
2. One-shot end: mode=1, phase_inc=0x10 -> samples 0..7000. playing drops after the 7000 output; subsequent ticks give 0 with valid.
3. Duration: mode=0, phase_inc=0x10, duration=3 -> 0, 1000, 2000; playing=0 after the third valid; later ticks give 0.
4. Interpolation extremes: ROM[0]=-32768, ROM[1]=32767, phase_inc=0x08 -> -32768, then -1 (floor); no overflow.
5. Trigger while busy: trigger 2 clk after the tick at idx=5 -> that sample equals 5000; the next tick outputs 0 (index 0). Trigger and tick in the same cycle -> outputs 0.
6. Overrun and reset: tick at +0 and +2 clk -> one valid and one overrun pulse. rst asserted in FETCH_B -> no valid; sample=0, playing=0 immediately.

Source files
------------

// File: rtl/wavetable_voice_player_pkg.sv
// Shared types for the wavetable voice player: FSM states, play modes and sample type.
package player_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_A = 3'd1,
    FETCH_B = 3'd2,
    LERP    = 3'd3,
    OUT     = 3'd4
  } player_state_t;

  typedef enum logic {
    MODE_LOOP    = 1'b0,
    MODE_ONESHOT = 1'b1
  } play_mode_t;

  typedef logic signed [15:0] sample_t;

  localparam int DEFAULT_FRAC_BITS = 16;

endpackage

// File: rtl/wavetable_voice_player_lerp.sv
// Linear interpolation a + floor((b - a) * frac / 2^FRAC_BITS), registered when en is high.
module player_lerp
  import player_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = DEFAULT_FRAC_BITS
) (
  input  logic                     mclk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic [FRAC_BITS-1:0]     frac,
  output logic signed [DATA_W-1:0] result_q
);

  localparam int PW = DATA_W + FRAC_BITS + 2;

  logic signed [DATA_W:0]   diff_s;
  logic signed [PW-1:0]     diff_x_s;
  logic signed [PW-1:0]     frac_x_s;
  logic signed [PW-1:0]     prod_s;
  logic signed [PW-1:0]     sum_s;
  logic signed [DATA_W-1:0] result_d;

  // Interpolation datapath; the sum always lands between a and b, so plain truncation is safe
  always_comb begin
    diff_s   = {b[DATA_W-1], b} - {a[DATA_W-1], a};
    diff_x_s = PW'(diff_s);
    frac_x_s = PW'({1'b0, frac});
    prod_s   = diff_x_s * frac_x_s;
    sum_s    = PW'(a) + (prod_s >>> FRAC_BITS);
    if (en) begin
      result_d = DATA_W'(sum_s);
    end else begin
      result_d = result_q;
    end
  end

  // Result register
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

endmodule

// File: rtl/wavetable_voice_player.sv
// Wavetable voice player: fractional phase accumulator, two-sample fetch, linear interpolation,
// loop / one-shot playback with trigger restart and per-note duration limit.
module wavetable_voice_player
  import player_pkg::*;
#(
  parameter int  CLIP_LEN  = 1024,
  parameter int  DATA_W    = 16,
  parameter int  FRAC_BITS = DEFAULT_FRAC_BITS,
  parameter int  INC_W     = 24,
  parameter int  DUR_W     = 16,
  localparam int AW        = $clog2(CLIP_LEN)
) (
  input  logic                     mclk,
  input  logic                     rst,
  input  logic                     sample_tick,
  input  logic                     trigger,
  input  logic                     mode,
  input  logic [INC_W-1:0]         phase_inc,
  input  logic [DUR_W-1:0]         duration,
  output logic [AW-1:0]            rd_addr,
  input  logic signed [DATA_W-1:0] rd_data,
  output logic signed [DATA_W-1:0] sample,
  output logic                     valid,
  output logic                     playing,
  output logic                     overrun
);

  localparam int PW = AW + FRAC_BITS;
  localparam int SW = ((INC_W > PW) ? INC_W : PW) + 1;

  player_state_t            state_q, state_d;
  play_mode_t               mode_q, mode_d, pend_mode_q, pend_mode_d, trig_mode_s;
  logic [PW-1:0]            phase_q, phase_d;
  logic [INC_W-1:0]         inc_q, inc_d;
  logic [DUR_W-1:0]         dur_cnt_q, dur_cnt_d, duration_q, duration_d;
  logic [DUR_W-1:0]         pend_dur_q, pend_dur_d, trig_dur_s, dur_next_s;
  logic                     trig_pend_q, trig_pend_d;
  logic                     playing_q, playing_d, valid_q, valid_d, overrun_q, overrun_d;
  logic [AW-1:0]            rd_addr_q, rd_addr_d, idx_s, nidx_s;
  logic [FRAC_BITS-1:0]     frac_s;
  logic signed [DATA_W-1:0] a_q, a_d, sample_q, sample_d, lerp_q;
  logic [SW-1:0]            sum_s;
  logic                     lerp_en_s, oneshot_end_s, dur_end_s;

  assign idx_s  = phase_q[PW-1:FRAC_BITS];
  assign frac_s = phase_q[FRAC_BITS-1:0];

  player_lerp #(
    .DATA_W    (DATA_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_lerp (
    .mclk     (mclk),
    .rst      (rst),
    .en       (lerp_en_s),
    .a        (a_q),
    .b        (rd_data),
    .frac     (frac_s),
    .result_q (lerp_q)
  );

  // Next-state logic for the fetch/interpolate/output sequence and note bookkeeping
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    pend_mode_d = pend_mode_q;
    phase_d     = phase_q;
    inc_d       = inc_q;
    dur_cnt_d   = dur_cnt_q;
    duration_d  = duration_q;
    pend_dur_d  = pend_dur_q;
    trig_pend_d = trig_pend_q;
    playing_d   = playing_q;
    rd_addr_d   = rd_addr_q;
    a_d         = a_q;
    sample_d    = sample_q;
    valid_d     = 1'b0;
    overrun_d   = sample_tick && (state_q != IDLE);
    lerp_en_s   = 1'b0;

    if ((mode_q == MODE_ONESHOT) && (idx_s == AW'(CLIP_LEN - 1))) begin
      nidx_s = idx_s;
    end else begin
      nidx_s = idx_s + AW'(1);
    end

    sum_s         = SW'(phase_q) + SW'(inc_q);
    dur_next_s    = dur_cnt_q + DUR_W'(1);
    oneshot_end_s = (mode_q == MODE_ONESHOT) && (sum_s[SW-1:PW] != '0);
    dur_end_s     = (duration_q != '0) && (dur_next_s == duration_q);
    trig_mode_s   = trigger ? play_mode_t'(mode) : pend_mode_q;
    trig_dur_s    = trigger ? duration : pend_dur_q;

    // A trigger outside IDLE is parked until the in-flight sample is emitted
    if (trigger && (state_q != IDLE)) begin
      trig_pend_d = 1'b1;
      pend_mode_d = play_mode_t'(mode);
      pend_dur_d  = duration;
    end else begin
      trig_pend_d = trig_pend_q;
    end

    case (state_q)
      IDLE: begin
        if (trigger) begin
          phase_d    = '0;
          dur_cnt_d  = '0;
          playing_d  = 1'b1;
          mode_d     = trig_mode_s;
          duration_d = trig_dur_s;
        end else begin
          playing_d = playing_q;
        end
        if (sample_tick) begin
          state_d   = FETCH_A;
          inc_d     = phase_inc;
          rd_addr_d = trigger ? '0 : idx_s;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH_A: begin
        rd_addr_d = nidx_s;
        state_d   = FETCH_B;
      end
      FETCH_B: begin
        a_d     = rd_data;
        state_d = LERP;
      end
      LERP: begin
        lerp_en_s = 1'b1;
        state_d   = OUT;
      end
      OUT: begin
        sample_d    = playing_q ? lerp_q : '0;
        valid_d     = 1'b1;
        state_d     = IDLE;
        trig_pend_d = 1'b0;
        if (trigger || trig_pend_q) begin
          phase_d    = '0;
          dur_cnt_d  = '0;
          playing_d  = 1'b1;
          mode_d     = trig_mode_s;
          duration_d = trig_dur_s;
        end else if (playing_q) begin
          dur_cnt_d = dur_next_s;
          phase_d   = oneshot_end_s ? phase_q : sum_s[PW-1:0];
          playing_d = !(oneshot_end_s || dur_end_s);
        end else begin
          phase_d = phase_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= MODE_LOOP;
      pend_mode_q <= MODE_LOOP;
      phase_q     <= '0;
      inc_q       <= '0;
      dur_cnt_q   <= '0;
      duration_q  <= '0;
      pend_dur_q  <= '0;
      trig_pend_q <= 1'b0;
      playing_q   <= 1'b0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      rd_addr_q   <= '0;
      a_q         <= '0;
      sample_q    <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      pend_mode_q <= pend_mode_d;
      phase_q     <= phase_d;
      inc_q       <= inc_d;
      dur_cnt_q   <= dur_cnt_d;
      duration_q  <= duration_d;
      pend_dur_q  <= pend_dur_d;
      trig_pend_q <= trig_pend_d;
      playing_q   <= playing_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      rd_addr_q   <= rd_addr_d;
      a_q         <= a_d;
      sample_q    <= sample_d;
    end
  end

  assign rd_addr = rd_addr_q;
  assign sample  = sample_q;
  assign valid   = valid_q;
  assign playing = playing_q;
  assign overrun = overrun_q;

endmodule
